// File: rtl/fd_pipe_reg_pkg.sv
// Shared constants and the D-stage record for the IF/ID pipeline register.
// Exception codes, the NOP encoding and instruction-memory defaults are reused by IFU, decode and CP0.
package fd_pipe_reg_pkg;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int          IM_DEPTH_DEF = 4096;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc8;
        logic        valid;
        logic        bd;
        logic        exc;
        logic [4:0]  exccode;
    } fd_stage_t;

endpackage

// File: rtl/fd_addr_chk.sv
// Combinational fetch-address checker: flags misaligned or out-of-range instruction addresses.
// The address under test is recovered from PC+8 with 32-bit wrap-around subtraction.
module fd_addr_chk
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_DEPTH = IM_DEPTH_DEF
) (
    input  logic [31:0] pc8_f_i,
    output logic        adel_o
);

    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_DEPTH) - 32'd4;

    logic [31:0] pc;

    always_comb begin
        pc     = pc8_f_i - 32'd8;
        adel_o = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    end

endmodule

// File: rtl/fd_pipe_reg.sv
// IF/ID pipeline register: latches instruction and PC+8, holds on stall, inserts a bubble on flush.
// Optional performance counters are built when FD_PERF_CNT_EN is defined.
module fd_pipe_reg
    import fd_pipe_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_DEPTH = IM_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc8_f,
    input  logic        br_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        bd_d,
    output logic        exc_d,
    output logic [4:0]  exccode_d,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam fd_stage_t STAGE_RST = '{
        instr:   NOP,
        pc8:     RESET_PC + 32'd8,
        valid:   1'b0,
        bd:      1'b0,
        exc:     1'b0,
        exccode: EXC_NONE
    };

    fd_stage_t stage_q;
    fd_stage_t stage_d;
    logic      adel;

    fd_addr_chk #(
        .IM_BASE  (IM_BASE),
        .IM_DEPTH (IM_DEPTH)
    ) u_addr_chk (
        .pc8_f_i (pc8_f),
        .adel_o  (adel)
    );

    // Flush wins over stall; the bubble still carries pc8_f so CP0 has a usable EPC.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d.instr   = NOP;
            stage_d.pc8     = pc8_f;
            stage_d.valid   = 1'b0;
            stage_d.bd      = 1'b0;
            stage_d.exc     = 1'b0;
            stage_d.exccode = EXC_NONE;
        end else if (!stall) begin
            stage_d.pc8     = pc8_f;
            stage_d.valid   = 1'b1;
            stage_d.bd      = br_d & stage_q.valid;
            stage_d.exc     = adel;
            stage_d.exccode = adel ? EXC_ADEL : EXC_NONE;
            stage_d.instr   = adel ? NOP : instr_f;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= STAGE_RST;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign instr_d   = stage_q.instr;
    assign pc8_d     = stage_q.pc8;
    assign valid_d   = stage_q.valid;
    assign bd_d      = stage_q.bd;
    assign exc_d     = stage_q.exc;
    assign exccode_d = stage_q.exccode;

`ifdef FD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Bench for fd_pipe_reg: directed vectors feed a reference model whose expected D-stage
// state is queued at each posedge and compared by a monitor at the following negedge.
module tb_fd_pipe_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc8;
        logic        valid;
        logic        bd;
        logic        exc;
        logic [4:0]  exccode;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    localparam int W = $bits(exp_t);

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] instr_f;
    logic [31:0] pc8_f;
    logic        br_d;
    logic [31:0] instr_d;
    logic [31:0] pc8_d;
    logic        valid_d;
    logic        bd_d;
    logic        exc_d;
    logic [4:0]  exccode_d;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    // Reference model state
    exp_t m;

    fd_pipe_reg dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .instr_f   (instr_f),
        .pc8_f     (pc8_f),
        .br_d      (br_d),
        .instr_d   (instr_d),
        .pc8_d     (pc8_d),
        .valid_d   (valid_d),
        .bd_d      (bd_d),
        .exc_d     (exc_d),
        .exccode_d (exccode_d),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        check("instr_d",   instr_d,           e.instr);
        check("pc8_d",     pc8_d,             e.pc8);
        check("valid_d",   {31'd0, valid_d},  {31'd0, e.valid});
        check("bd_d",      {31'd0, bd_d},     {31'd0, e.bd});
        check("exc_d",     {31'd0, exc_d},    {31'd0, e.exc});
        check("exccode_d", {27'd0, exccode_d}, {27'd0, e.exccode});
        check("stall_cnt", stall_cnt,         e.stall_cnt);
        check("flush_cnt", flush_cnt,         e.flush_cnt);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_all(exp_t'(exp_q.pop_front()));
        end
    end

    // ---------------- model ----------------
    task automatic model_reset();
        m.instr     = 32'h0;
        m.pc8       = 32'h0000_3008;
        m.valid     = 1'b0;
        m.bd        = 1'b0;
        m.exc       = 1'b0;
        m.exccode   = 5'd0;
        m.stall_cnt = 32'd0;
        m.flush_cnt = 32'd0;
    endtask

    task automatic model_edge(input logic s, input logic f, input logic [31:0] ins,
                              input logic [31:0] p8, input logic b);
        logic [31:0] pc;
        logic        err;
        pc  = p8 - 32'd8;
        err = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
        if (f) begin
            m.instr   = 32'h0;
            m.pc8     = p8;
            m.valid   = 1'b0;
            m.bd      = 1'b0;
            m.exc     = 1'b0;
            m.exccode = 5'd0;
`ifdef FD_PERF_CNT_EN
            if (m.flush_cnt != 32'hFFFF_FFFF) m.flush_cnt = m.flush_cnt + 32'd1;
`endif
        end else if (s) begin
`ifdef FD_PERF_CNT_EN
            if (m.stall_cnt != 32'hFFFF_FFFF) m.stall_cnt = m.stall_cnt + 32'd1;
`endif
        end else begin
            m.bd      = b & m.valid;
            m.valid   = 1'b1;
            m.pc8     = p8;
            m.instr   = err ? 32'h0 : ins;
            m.exc     = err;
            m.exccode = err ? 5'd4 : 5'd0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic s, input logic f, input logic [31:0] ins,
                        input logic [31:0] p8, input logic b);
        stall   = s;
        flush   = f;
        instr_f = ins;
        pc8_f   = p8;
        br_d    = b;
        @(posedge clk);
        model_edge(s, f, ins, p8, b);
        exp_q.push_back(W'(m));
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with garbage inputs
        reset   = 1'b1;
        stall   = 1'b1;
        flush   = 1'b1;
        instr_f = 32'hDEAD_BEEF;
        pc8_f   = 32'h1234_5678;
        br_d    = 1'b1;
        model_reset();
        exp_q.push_back(W'(m));
        @(negedge clk);
        check("reset pc8_d const", pc8_d, 32'h0000_3008);
        reset = 1'b0;

        // First advance after release
        step(1'b0, 1'b0, 32'h3c01_0001, 32'h0000_3008, 1'b0);
        check("first instr const", instr_d, 32'h3c01_0001);

        // beq in D, then its delay slot
        step(1'b0, 1'b0, 32'h1022_0003, 32'h0000_300C, 1'b0);
        step(1'b0, 1'b0, 32'h2042_0001, 32'h0000_3010, 1'b1);
        check("delay slot bd const", {31'd0, bd_d}, 32'd1);

        // Three stall cycles with changing fetch inputs
        step(1'b1, 1'b0, 32'h1111_1111, 32'h0000_3014, 1'b0);
        step(1'b1, 1'b0, 32'h2222_2222, 32'h0000_3018, 1'b1);
        step(1'b1, 1'b0, 32'h3333_3333, 32'h0000_301C, 1'b0);

        // Flush and stall together: bubble with pc8_f as EPC
        step(1'b1, 1'b1, 32'h4444_4444, 32'h0000_3020, 1'b1);
        check("flush instr const", instr_d, 32'h0);
        check("flush pc8 const", pc8_d, 32'h0000_3020);

        // Branch flagged while D holds a bubble: no delay slot
        step(1'b0, 1'b0, 32'h5555_5555, 32'h0000_3024, 1'b1);

        // Address checks
        step(1'b0, 1'b0, 32'h6666_6666, 32'h0000_300A, 1'b0);  // misaligned
        check("adel code const", {27'd0, exccode_d}, 32'd4);
        step(1'b1, 1'b0, 32'h7777_7777, 32'h0000_3030, 1'b0);  // stall holds exc
        step(1'b0, 1'b0, 32'h8888_8888, 32'h0000_7004, 1'b0);  // last legal word
        step(1'b0, 1'b0, 32'h9999_9999, 32'h0000_7008, 1'b0);  // one past end
        step(1'b1, 1'b1, 32'hAAAA_AAAA, 32'h0000_700C, 1'b0);  // flush clears exc
        step(1'b0, 1'b0, 32'hBBBB_BBBB, 32'h0000_0004, 1'b0);  // wraps negative
        step(1'b0, 1'b0, 32'hCCCC_CCCC, 32'h0000_3004, 1'b1);  // below base
        step(1'b0, 1'b0, 32'hDDDD_DDDD, 32'h0000_3008, 1'b1);  // base is legal
        check("base legal exc const", {31'd0, exc_d}, 32'd0);

`ifdef FD_PERF_CNT_EN
        // Counter saturation
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m.stall_cnt = 32'hFFFF_FFFE;
        step(1'b1, 1'b0, 32'h0, 32'h0000_3010, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0000_3010, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0000_3010, 1'b0);
        check("stall_cnt sat const", stall_cnt, 32'hFFFF_FFFF);
`endif

        // Asynchronous reset in the middle of a stall+flush cycle
        stall   = 1'b1;
        flush   = 1'b1;
        instr_f = 32'hFEED_FACE;
        pc8_f   = 32'h0000_5000;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(m);
        exp_q.push_back(W'(m));
        @(negedge clk);
        reset = 1'b0;

        // First edge after release is a normal advance; br_d cannot make a delay slot yet
        step(1'b0, 1'b0, 32'h2401_0005, 32'h0000_3008, 1'b1);
        step(1'b0, 1'b0, 32'h2401_0006, 32'h0000_300C, 1'b1);

        #1;
        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
